// File: rtl/subservient_dbg_loader_if.sv
// subservient_dbg_loader_if: byte-stream input, debug Wishbone write port and status of the loader
interface subservient_dbg_loader_if #(
    parameter int DW = 32
);
    logic [7:0]      i_byte_data;
    logic            i_byte_valid;
    logic            i_byte_last;
    logic            o_byte_ready;
    logic            o_debug_mode;
    logic [31:0]     o_wb_adr;
    logic [DW-1:0]   o_wb_dat;
    logic [DW/8-1:0] o_wb_sel;
    logic            o_wb_we;
    logic            o_wb_stb;
    logic            i_wb_ack;
    logic            o_done;
    logic            o_overflow;

    modport master (
        input  i_byte_data, i_byte_valid, i_byte_last, i_wb_ack,
        output o_byte_ready, o_debug_mode, o_wb_adr, o_wb_dat, o_wb_sel,
               o_wb_we, o_wb_stb, o_done, o_overflow
    );

    modport slave (
        output i_byte_data, i_byte_valid, i_byte_last, i_wb_ack,
        input  o_byte_ready, o_debug_mode, o_wb_adr, o_wb_dat, o_wb_sel,
               o_wb_we, o_wb_stb, o_done, o_overflow
    );
endinterface

// File: rtl/subservient_dbg_loader.sv
// subservient_dbg_loader: packs an image byte stream into little-endian words and writes them over the debug Wishbone port
module subservient_dbg_loader #(
    parameter int          DW          = 32,
    parameter int          MEMSIZE     = 8192,
    parameter logic [31:0] BASE_ADR    = 32'h0,
    parameter int          PRE_CYCLES  = 10,
    parameter int          POST_CYCLES = 10
) (
    input logic i_clk,
    input logic i_rst,
    subservient_dbg_loader_if.master bus
);
    localparam int NB = DW / 8;
    localparam int LW = $clog2(NB);
    localparam int CB = $clog2(MEMSIZE + 1);
    localparam int GW = $clog2((PRE_CYCLES > POST_CYCLES ? PRE_CYCLES : POST_CYCLES) + 1);

    localparam logic [2:0] S_PRE   = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [GW-1:0] gcnt;
    logic [LW-1:0] lane;
    logic [CB-1:0] bcnt;
    logic [DW-1:0] acc;
    logic [31:0]   nadr;
    logic          fin;
    logic          accept;
    logic          at_cap;
    logic          word_end;
    logic [DW-1:0] word;

    // acc keeps unused lanes at zero, so a short final word is padded for free
    always_comb begin
        accept   = bus.i_byte_valid & bus.o_byte_ready;
        at_cap   = bcnt == CB'(MEMSIZE - 1);
        word_end = bus.i_byte_last | at_cap | (lane == LW'(NB - 1));
        word     = acc | (DW'(bus.i_byte_data) << (8 * lane));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= S_PRE;
            gcnt             <= '0;
            lane             <= '0;
            bcnt             <= '0;
            acc              <= '0;
            nadr             <= BASE_ADR;
            fin              <= 1'b0;
            bus.o_byte_ready <= 1'b0;
            bus.o_debug_mode <= 1'b1;
            bus.o_wb_adr     <= '0;
            bus.o_wb_dat     <= '0;
            bus.o_wb_sel     <= '0;
            bus.o_wb_we      <= 1'b0;
            bus.o_wb_stb     <= 1'b0;
            bus.o_done       <= 1'b0;
            bus.o_overflow   <= 1'b0;
        end else begin
            case (state)
                S_PRE: begin
                    gcnt <= gcnt + 1'b1;
                    if (gcnt == GW'(PRE_CYCLES - 1)) begin
                        state            <= S_FILL;
                        bus.o_byte_ready <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        bcnt             <= bcnt + 1'b1;
                        lane             <= lane + 1'b1;
                        acc[8*lane +: 8] <= bus.i_byte_data;
                        if (word_end) begin
                            state            <= S_WRITE;
                            lane             <= '0;
                            acc              <= '0;
                            fin              <= bus.i_byte_last | at_cap;
                            bus.o_byte_ready <= 1'b0;
                            bus.o_wb_stb     <= 1'b1;
                            bus.o_wb_we      <= 1'b1;
                            bus.o_wb_sel     <= '1;
                            bus.o_wb_dat     <= word;
                            bus.o_wb_adr     <= nadr;
                            bus.o_overflow   <= at_cap & ~bus.i_byte_last;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.i_wb_ack) begin
                        nadr         <= nadr + 32'(NB);
                        bus.o_wb_stb <= 1'b0;
                        bus.o_wb_we  <= 1'b0;
                        bus.o_wb_sel <= '0;
                        if (fin) begin
                            state <= S_POST;
                            gcnt  <= '0;
                        end else begin
                            state            <= S_FILL;
                            bus.o_byte_ready <= 1'b1;
                        end
                    end
                end
                S_POST: begin
                    gcnt <= gcnt + 1'b1;
                    if (gcnt == GW'(POST_CYCLES - 1)) begin
                        state            <= S_DONE;
                        bus.o_debug_mode <= 1'b0;
                        bus.o_done       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/subservient_dbg_loader.md
# subservient_dbg_loader

Synthesizable firmware loader that drives the subservient debug Wishbone port. It accepts a byte stream of a program image and packs bytes little-endian into bus-width words. It issues one Wishbone write per word, zero-pads the final partial word, and holds the SoC in debug mode until loading completes. It sits between a byte source (UART receiver, SPI flash reader, test bench) and the `i_debug_mode`/`i_wb_dbg_*` inputs of the SoC. It generalises the load sequence to any bus width, memory size, base address and guard-interval lengths.

## Interface
Parameters:
- `DW`, 32 — Wishbone data width in bits; multiple of 8, ≥ 16. `NB = DW/8` bytes per word.
- `MEMSIZE`, 8192 — maximum image size in bytes.
- `BASE_ADR`, 0 — byte address of the first word; NB-aligned.
- `PRE_CYCLES`, 10 — idle cycles in debug mode before the first byte is accepted; ≥ 1.
- `POST_CYCLES`, 10 — idle cycles after the last write ack before debug mode is released; ≥ 1.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset. Synchronous and active-high.
- `i_byte_data`  in  8  image byte.
- `i_byte_valid`  in  1  byte present.
- `i_byte_last`  in  1  qualifies `i_byte_valid`; this byte is the final byte of the image.
- `o_byte_ready`  out  1  loader accepts a byte this cycle.
- `o_debug_mode`  out  1  drives SoC `i_debug_mode`.
- `o_wb_adr`  out  32  write address (byte address).
- `o_wb_dat`  out  DW  write data.
- `o_wb_sel`  out  NB  byte select.
- `o_wb_we`  out  1  write enable.
- `o_wb_stb`  out  1  strobe; also used as cycle.
- `i_wb_ack`  in  1  acknowledge.
- `o_done`  out  1  load complete; sticky until reset.
- `o_overflow`  out  1  image was truncated at MEMSIZE; sticky until reset.

## Operation
- **States:**
  - `PRE` — count PRE_CYCLES.
  - `FILL` — `o_byte_ready`=1; accept bytes.
  - `WRITE` — strobe is asserted; wait for ack.
  - `POST` — count POST_CYCLES.
  - `DONE` — terminal state.
- **Transitions:**
  - `PRE` → `FILL` after PRE_CYCLES cycles.
  - `FILL` → `WRITE` on acceptance of the final lane byte, of the `i_byte_last` byte, or of byte number MEMSIZE.
  - `WRITE` → `FILL` on ack, if the image is not finished.
  - `WRITE` → `POST` on ack, if the image is finished.
  - `POST` → `DONE` after POST_CYCLES cycles.
- **Byte acceptance:** a byte is accepted when `i_byte_valid & o_byte_ready`. Byte k of a word goes to lane `o_wb_dat[8k+:8]`; k counts 0..NB-1.
- **Partial word:** on last or truncation with fewer than NB bytes, the remaining lanes are 0.
- **Write cycle constants:** `o_wb_sel` is all ones and `o_wb_we`=1 for every write.
- **Address:** `o_wb_adr` = `BASE_ADR + word_index*NB`. The word index starts at 0 and increments after each ack. Address arithmetic is 32-bit modulo.
- **Byte counter:** width `$clog2(MEMSIZE+1)`. When the accepted byte count reaches MEMSIZE, that byte is treated as last. If `i_byte_last` was 0 on that byte, `o_overflow` is set.
- **After the final byte:** `o_byte_ready` stays 0 permanently, until reset.
- **`i_byte_last`:** ignored when `i_byte_valid` is 0.
- **`o_debug_mode`:** 1 from reset through `POST`; 0 in `DONE`. `o_done` is 1 in `DONE`.
- **Reset:** returns to `PRE` from any state, including mid-`WRITE` with `o_wb_stb` high. The partial word, counters and sticky flags are discarded.

## Timing
- **Reset values:**
  - `o_debug_mode`=1.
  - `o_byte_ready`=0.
  - `o_wb_stb`=0, `o_wb_we`=0, `o_wb_sel`=0.
  - `o_wb_adr`=0, `o_wb_dat`=0.
  - `o_done`=0, `o_overflow`=0.
- **All outputs are registered.**
- **Guard intervals:**
  - First cycle with `o_byte_ready`=1 is cycle PRE_CYCLES after reset deasserts. Cycle 0 is the first cycle with `i_rst`=0.
  - `o_debug_mode` falls exactly POST_CYCLES+1 cycles after the cycle in which the final ack is sampled.
- **Byte-to-strobe latency:** `o_wb_stb`, `o_wb_adr`, `o_wb_dat`, `o_wb_sel` and `o_wb_we` rise on the edge that accepts the word-completing byte. The strobe is visible the next cycle.
- **`o_byte_ready`:** falls on that same edge, so no byte is accepted while `WRITE` is active.
- **Strobe hold:** `o_wb_stb` holds, with address and data stable, until `i_wb_ack` is sampled high. It deasserts on that edge.
- **Acks outside `WRITE`:** ignored.
- **Return to `FILL`:** `o_byte_ready` is 1 in the cycle after the ack, for non-final words.
- **Throughput:** NB+1 cycles per word with a zero-wait-state slave that acks in the first strobe cycle.
- **Overflow timing:** `o_overflow` rises on the edge that accepts the truncating byte.

## Test plan
- **Two full words:** DW=32, bytes 11..88, last on 88, 0-wait ack → writes {adr 0, dat 0x44332211} and {adr 4, dat 0x88776655}, sel 0xF. `o_debug_mode` falls 11 cycles after the second ack; `o_done`=1.
- **Partial final word:** 5 bytes 11 22 33 44 55, last on 55 → second write dat 0x00000055 at adr 4, sel 0xF.
- **Slow slave and source:** ack after 3 strobe cycles; `i_byte_valid` toggling every other cycle → `o_wb_stb` high exactly 3 cycles with stable adr/dat; `o_byte_ready` low throughout; no bytes lost.
- **Truncation:** MEMSIZE=16, 20 bytes offered, never last → 4 writes (adr 0..12); `o_overflow`=1; `o_byte_ready`=0 thereafter; bytes 17..20 never accepted.
- **Wide bus with base address:** DW=64, BASE_ADR=0x100, 9 bytes 01..09 → writes {0x100, 0x0807060504030201} and {0x108, 0x0000000000000009}, sel 0xFF.
- **Reset mid-write:** assert `i_rst` while `o_wb_stb`=1 → next cycle `o_wb_stb`=0 and `o_debug_mode`=1. A reload of 4 bytes then writes adr `BASE_ADR` with the new data.
